// File: rtl/dice_pkg.sv
// Shared constants for the dice roll unit: FSM encoding, die range,
// LFSR polynomial and the SAMPLE retry bound.
package dice_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      DONE   = 2'd2,
      HOLD   = 2'd3
   } state_t;

   localparam logic [2:0]  DIE_MIN      = 3'd1;
   localparam logic [2:0]  DIE_MAX      = 3'd6;
   // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam int          SAMPLE_LIMIT = 16;

   // One Fibonacci shift: feedback enters at bit 0.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

   // Next face in the tumble sequence 1,2..6,1.
   function automatic logic [2:0] die_step(input logic [2:0] v);
      return (v >= DIE_MAX) ? DIE_MIN : v + 3'd1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-FF synchroniser followed by a stability counter.
// level is active-high "pressed"; pulses are one cycle wide and coincide
// with the cycle in which level changes.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          sampled;

   // sync[1] is the metastability-safe sample; key_n idles high (released)
   always_ff @(posedge clk) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], key_n};
   end

   assign sampled = ~sync[1];

   // Count consecutive samples that disagree with the accepted level; any
   // sample agreeing with it again restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         level         <= 1'b0;
         cnt           <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         if (sampled == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt           <= '0;
            level         <= sampled;
            press_pulse   <= sampled;
            release_pulse <= ~sampled;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/dice_roll_unit.sv
// Dice roll unit: debounced roll key, free-running LFSR, rejection sampling
// of lfsr[2:0] into a 1..6 result with a one-cycle roll_valid strobe.
// Optional feature macro ROLL_ANIM_EN adds disp_value and the tumble animation.
module dice_roll_unit
   import dice_pkg::*;
#(
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
`ifdef ROLL_ANIM_EN
   ,
   parameter int          ANIM_DIV        = 2500000
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_n,
   input  logic       roll_en,
   output logic [2:0] roll_value,
   output logic       roll_valid,
   output logic       busy,
`ifdef ROLL_ANIM_EN
   output logic [2:0] disp_value,
`endif
   output logic [7:0] roll_count
);

   state_t      state;
   logic [15:0] lfsr;
   logic [2:0]  cand;
   logic        cand_ok;
   logic [3:0]  sample_cnt;
   logic        take;
   logic [2:0]  take_value;
   logic        rel_seen;
   logic        pressed_lvl;
   logic        press_pulse;
   logic        release_pulse;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .clk          (clk),
      .rst          (rst),
      .key_n        (key_n),
      .level        (pressed_lvl),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse)
   );

   // Free-running source; timing of the human press supplies the entropy
   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= lfsr_next(lfsr);
   end

   assign cand       = lfsr[2:0];
   assign cand_ok    = (cand >= DIE_MIN) && (cand <= DIE_MAX);
   // Accept a valid candidate, or fall back to 1 once the retry budget is spent
   assign take       = (state == SAMPLE) &&
                       (cand_ok || (sample_cnt == 4'(SAMPLE_LIMIT - 1)));
   assign take_value = cand_ok ? cand : DIE_MIN;
   assign busy       = (state != IDLE);

   // Roll FSM; roll_valid is raised on entry to DONE so it is high exactly there
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         roll_value <= 3'd0;
         roll_valid <= 1'b0;
         roll_count <= 8'd0;
         sample_cnt <= 4'd0;
         rel_seen   <= 1'b0;
      end else begin
         roll_valid <= 1'b0;
         case (state)
            IDLE: begin
               sample_cnt <= 4'd0;
               rel_seen   <= 1'b0;
               // A press while rolls are disabled is swallowed: it must be released first
               if (press_pulse) state <= roll_en ? SAMPLE : HOLD;
            end
            SAMPLE: begin
               if (release_pulse) rel_seen <= 1'b1;
               if (take) begin
                  roll_value <= take_value;
                  roll_count <= roll_count + 8'd1;
                  roll_valid <= 1'b1;
                  state      <= DONE;
               end else begin
                  sample_cnt <= sample_cnt + 4'd1;
               end
            end
            DONE: begin
               if (release_pulse) rel_seen <= 1'b1;
               state <= HOLD;
            end
            HOLD: begin
               // Released level also covers a release that happens while in HOLD
               if (rel_seen || !pressed_lvl) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ROLL_ANIM_EN
   localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);

   logic          anim_armed;
   logic [2:0]    anim_val;
   logic [AW-1:0] anim_cnt;

   // Tumble starts from the fresh result and advances every ANIM_DIV cycles in HOLD
   always_ff @(posedge clk) begin
      if (rst) begin
         anim_armed <= 1'b0;
         anim_val   <= 3'd0;
         anim_cnt   <= '0;
      end else if (take) begin
         anim_armed <= 1'b1;
         anim_val   <= take_value;
         anim_cnt   <= '0;
      end else if ((state == HOLD) && anim_armed) begin
         if (anim_cnt == ANIM_LAST) begin
            anim_cnt <= '0;
            anim_val <= die_step(anim_val);
         end else begin
            anim_cnt <= anim_cnt + AW'(1);
         end
      end else if (state == IDLE) begin
         anim_armed <= 1'b0;
      end
   end

   assign disp_value = ((state == HOLD) && anim_armed) ? anim_val : roll_value;
`endif

endmodule
